inst_mem_ctrl: RTL and testbench

Instruction-side memory controller directly upstream of the fetch stage. It serves fetch's start/ready/valid handshake and translates each request into a transaction on a variable-latency word-read bus (req held until ack).
- Range/alignment checking and timeout recovery are done here, so fetch always receives exactly one response per accepted request.
- Sits between fetch and the instruction RAM / bus arbiter.

---
 rtl/inst_mem_ctrl_if.sv | 61 ++++++
 rtl/inst_mem_ctrl.sv | 146 ++++++++++++++
 tb/tb_inst_mem_ctrl.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/inst_mem_ctrl_if.sv
// Interfaces for the instruction memory controller.
//
// mem_fetch_if : fetch <-> controller start/ready/valid handshake.
//   master = fetch stage, slave = controller.
//   mem_start/mem_addr       : request strobe and byte address from fetch.
//   mem_ready                : controller can accept a request this cycle.
//   mem_data/mem_data_valid  : response word and its one-cycle qualifier.
//   mem_fault                : response is a NOP due to misalignment, range or timeout.
//
// mem_bus_if : controller <-> instruction RAM / arbiter word-read bus.
//   master = controller, slave = memory.
//   bus_req/bus_addr         : read request, held until bus_ack.
//   bus_ack/bus_rdata        : completion strobe and read data.

interface mem_fetch_if;
    logic        mem_start;
    logic        mem_ready;
    logic [31:0] mem_addr;
    logic [31:0] mem_data;
    logic        mem_data_valid;
    logic        mem_fault;

    modport master (
        output mem_start,
        output mem_addr,
        input  mem_ready,
        input  mem_data,
        input  mem_data_valid,
        input  mem_fault
    );

    modport slave (
        input  mem_start,
        input  mem_addr,
        output mem_ready,
        output mem_data,
        output mem_data_valid,
        output mem_fault
    );
endinterface

interface mem_bus_if;
    logic        bus_req;
    logic [31:0] bus_addr;
    logic        bus_ack;
    logic [31:0] bus_rdata;

    modport master (
        output bus_req,
        output bus_addr,
        input  bus_ack,
        input  bus_rdata
    );

    modport slave (
        input  bus_req,
        input  bus_addr,
        output bus_ack,
        output bus_rdata
    );
endinterface

// File: rtl/inst_mem_ctrl.sv
// Instruction-side memory controller sitting between fetch and the
// instruction RAM / bus arbiter. Every accepted fetch request gets exactly
// one response: either the bus read data, or INST_NOP with mem_fault set
// when the address is misaligned, out of range, or the bus times out.
//
// Ports:
//   clk        : clock, rising edge
//   rst_n      : asynchronous active-low reset
//   fetch      : mem_fetch_if.slave, handshake with the fetch stage
//   bus        : mem_bus_if.master, variable-latency word-read bus
//   req_count  : accepted requests since reset, wraps at 2^32
//
// State | meaning
// ------+-------------------------------------------------------------
// IDLE  | no request outstanding, ready to accept
// BUS   | bus_req asserted, waiting for bus_ack or timeout
// RESP  | response presented for one cycle, may accept the next request

module inst_mem_ctrl #(
    parameter logic [31:0] MEM_SIZE = 32'h0001_0000,
    parameter int          TIMEOUT  = 64,
    parameter logic [31:0] INST_NOP = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    mem_fetch_if.slave  fetch,
    mem_bus_if.master   bus,
    output logic [31:0] req_count
);

    localparam int            CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TC = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUS  = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t        state_q, state_nx;
    logic          bus_req_q, bus_req_nx;
    logic [31:0]   bus_addr_q, bus_addr_nx;
    logic [31:0]   mem_data_q, mem_data_nx;
    logic          mem_fault_q, mem_fault_nx;
    logic [CW-1:0] cnt_q, cnt_nx;
    logic [31:0]   req_count_q, req_count_nx;

    logic          ready;
    logic          accept;
    logic          addr_fault;

    // ready depends only on state so fetch can derive mem_start from it
    // without forming a combinational loop.
    assign ready = (state_q != S_BUS);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_nx;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_req_q   <= 1'b0;
            bus_addr_q  <= 32'h0;
            mem_data_q  <= INST_NOP;
            mem_fault_q <= 1'b0;
            cnt_q       <= '0;
            req_count_q <= 32'h0;
        end else begin
            bus_req_q   <= bus_req_nx;
            bus_addr_q  <= bus_addr_nx;
            mem_data_q  <= mem_data_nx;
            mem_fault_q <= mem_fault_nx;
            cnt_q       <= cnt_nx;
            req_count_q <= req_count_nx;
        end
    end

    always_comb begin
        state_nx     = state_q;
        bus_req_nx   = bus_req_q;
        bus_addr_nx  = bus_addr_q;
        mem_data_nx  = mem_data_q;
        mem_fault_nx = mem_fault_q;
        cnt_nx       = cnt_q;
        req_count_nx = req_count_q;

        accept     = fetch.mem_start && ready;
        addr_fault = (fetch.mem_addr[1:0] != 2'b00) || (fetch.mem_addr >= MEM_SIZE);

        case (state_q)
            // RESP shares the accept path with IDLE so fetch can issue
            // back-to-back in the response cycle.
            S_IDLE, S_RESP: begin
                state_nx = S_IDLE;
                if (accept) begin
                    req_count_nx = req_count_q + 32'd1;
                    if (addr_fault) begin
                        state_nx     = S_RESP;
                        mem_data_nx  = INST_NOP;
                        mem_fault_nx = 1'b1;
                    end else begin
                        state_nx    = S_BUS;
                        bus_req_nx  = 1'b1;
                        bus_addr_nx = fetch.mem_addr;
                        cnt_nx      = '0;
                    end
                end
            end

            S_BUS: begin
                // An ack in the terminal cycle still delivers data.
                if (bus.bus_ack) begin
                    state_nx     = S_RESP;
                    bus_req_nx   = 1'b0;
                    mem_data_nx  = bus.bus_rdata;
                    mem_fault_nx = 1'b0;
                end else if (cnt_q == TC) begin
                    state_nx     = S_RESP;
                    bus_req_nx   = 1'b0;
                    mem_data_nx  = INST_NOP;
                    mem_fault_nx = 1'b1;
                end else begin
                    cnt_nx = cnt_q + CW'(1);
                end
            end

            default: begin
                state_nx   = S_IDLE;
                bus_req_nx = 1'b0;
            end
        endcase
    end

    assign fetch.mem_ready      = ready;
    assign fetch.mem_data       = mem_data_q;
    assign fetch.mem_data_valid = (state_q == S_RESP);
    assign fetch.mem_fault      = mem_fault_q;
    assign bus.bus_req          = bus_req_q;
    assign bus.bus_addr         = bus_addr_q;
    assign req_count            = req_count_q;

endmodule

// File: tb/tb_inst_mem_ctrl.sv
module tb_inst_mem_ctrl;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk;
    logic        rst_n;
    logic [31:0] req_count;

    mem_fetch_if fetch_if ();
    mem_bus_if   bus_if ();

    inst_mem_ctrl #(
        .MEM_SIZE (32'h0001_0000),
        .TIMEOUT  (64),
        .INST_NOP (NOP)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .fetch     (fetch_if),
        .bus       (bus_if),
        .req_count (req_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks;
    int errors;
    int exp_count;

    typedef struct {
        string       name;
        logic [31:0] addr;
        int          ack_dly;   // BUS cycle index carrying bus_ack, -1 = never
        logic [31:0] rdata;
        logic        fault;
        logic [31:0] data;
        int          lat;       // edges from accept edge to valid, inclusive
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        fetch_if.mem_start = 1'b0;
        bus_if.bus_ack     = 1'b0;
        #2;
        rst_n = 1'b0;
        #20;
        rst_n = 1'b1;
        exp_count = 0;
        step();
    endtask

    task automatic run_vec(input vec_t v);
        int lat;
        int bus_cycles;
        bit bus_ok;
        fetch_if.mem_start = 1'b1;
        fetch_if.mem_addr  = v.addr;
        chk({v.name, "_ready"}, 32'(fetch_if.mem_ready), 32'd1);
        step();
        fetch_if.mem_start = 1'b0;
        exp_count++;
        lat        = 1;
        bus_cycles = 0;
        bus_ok     = 1'b1;
        while (!fetch_if.mem_data_valid && lat < 200) begin
            if (bus_if.bus_req) begin
                bus_cycles++;
                if (bus_if.bus_addr !== v.addr || fetch_if.mem_ready !== 1'b0) bus_ok = 1'b0;
            end
            bus_if.bus_ack   = (lat - 1 == v.ack_dly);
            bus_if.bus_rdata = v.rdata;
            step();
            lat++;
            bus_if.bus_ack = 1'b0;
        end
        chk({v.name, "_latency"}, 32'(lat), 32'(v.lat));
        chk({v.name, "_bus_cycles"}, 32'(bus_cycles), 32'(v.lat - 1));
        chk({v.name, "_bus_addr_stable"}, 32'(bus_ok), 32'd1);
        chk({v.name, "_data"}, fetch_if.mem_data, v.data);
        chk({v.name, "_fault"}, 32'(fetch_if.mem_fault), 32'(v.fault));
        chk({v.name, "_resp_ready"}, 32'(fetch_if.mem_ready), 32'd1);
        chk({v.name, "_req_count"}, req_count, 32'(exp_count));
        step();
        chk({v.name, "_valid_pulse"}, 32'(fetch_if.mem_data_valid), 32'd0);
        chk({v.name, "_data_held"}, fetch_if.mem_data, v.data);
        chk({v.name, "_bus_idle"}, 32'(bus_if.bus_req), 32'd0);
    endtask

    initial begin
        bit ok;
        checks    = 0;
        errors    = 0;
        exp_count = 0;

        vecs[0] = '{"rd_100",      32'h0000_0100,  0, 32'h0000_0093, 1'b0, 32'h0000_0093,  2};
        vecs[1] = '{"misaligned",  32'h0000_0102,  0, 32'hBAD0_0001, 1'b1, NOP,            1};
        vecs[2] = '{"out_range",   32'h0001_0000,  0, 32'hBAD0_0002, 1'b1, NOP,            1};
        vecs[3] = '{"last_word",   32'h0000_FFFC,  2, 32'hDEAD_BEEF, 1'b0, 32'hDEAD_BEEF,  4};
        vecs[4] = '{"timeout",     32'h0000_0200, -1, 32'hBAD0_0003, 1'b1, NOP,           65};
        vecs[5] = '{"ack_at_tc",   32'h0000_0204, 63, 32'h1234_5678, 1'b0, 32'h1234_5678, 65};
        vecs[6] = '{"rd_0_wait5",  32'h0000_0000,  5, 32'hA5A5_0001, 1'b0, 32'hA5A5_0001,  7};
        vecs[7] = '{"mis_hi",      32'h0000_FFFD,  0, 32'hBAD0_0004, 1'b1, NOP,            1};
        vecs[8] = '{"top_addr",    32'hFFFF_FFFC,  0, 32'hBAD0_0005, 1'b1, NOP,            1};

        rst_n              = 1'b0;
        fetch_if.mem_start = 1'b0;
        fetch_if.mem_addr  = 32'h0;
        bus_if.bus_ack     = 1'b0;
        bus_if.bus_rdata   = 32'h0;
        #22;
        rst_n = 1'b1;
        step();

        chk("rst_ready",     32'(fetch_if.mem_ready), 32'd1);
        chk("rst_bus_req",   32'(bus_if.bus_req), 32'd0);
        chk("rst_bus_addr",  bus_if.bus_addr, 32'h0);
        chk("rst_data",      fetch_if.mem_data, NOP);
        chk("rst_valid",     32'(fetch_if.mem_data_valid), 32'd0);
        chk("rst_fault",     32'(fetch_if.mem_fault), 32'd0);
        chk("rst_req_count", req_count, 32'd0);

        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // back-to-back: mem_start held, ack in third BUS cycle each time
        do_reset();
        fetch_if.mem_start = 1'b1;
        fetch_if.mem_addr  = 32'h0;
        step();
        for (int t = 0; t < 3; t++) begin
            ok = 1'b1;
            for (int k = 0; k < 3; k++) begin
                if (fetch_if.mem_ready !== 1'b0 || bus_if.bus_req !== 1'b1 ||
                    bus_if.bus_addr !== 32'(t * 4) || fetch_if.mem_data_valid !== 1'b0) ok = 1'b0;
                bus_if.bus_ack   = (k == 2);
                bus_if.bus_rdata = 32'h100 + 32'(t);
                step();
                bus_if.bus_ack = 1'b0;
            end
            chk("b2b_bus_phase", 32'(ok), 32'd1);
            chk("b2b_valid", 32'(fetch_if.mem_data_valid), 32'd1);
            chk("b2b_data", fetch_if.mem_data, 32'h100 + 32'(t));
            chk("b2b_fault", 32'(fetch_if.mem_fault), 32'd0);
            if (t < 2) fetch_if.mem_addr = 32'((t + 1) * 4);
            else       fetch_if.mem_start = 1'b0;
            step();
            chk("b2b_next_req", 32'(bus_if.bus_req), (t < 2) ? 32'd1 : 32'd0);
        end
        chk("b2b_req_count", req_count, 32'd3);

        // reset in the middle of a bus transaction
        fetch_if.mem_start = 1'b1;
        fetch_if.mem_addr  = 32'h0000_0300;
        step();
        fetch_if.mem_start = 1'b0;
        step();
        step();
        chk("mid_bus_req_before", 32'(bus_if.bus_req), 32'd1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("mid_async_bus_req", 32'(bus_if.bus_req), 32'd0);
        chk("mid_async_valid",   32'(fetch_if.mem_data_valid), 32'd0);
        chk("mid_async_count",   req_count, 32'd0);
        chk("mid_async_addr",    bus_if.bus_addr, 32'h0);
        #10;
        rst_n            = 1'b1;
        bus_if.bus_ack   = 1'b1;
        bus_if.bus_rdata = 32'h0000_0055;
        ok = 1'b1;
        for (int k = 0; k < 5; k++) begin
            step();
            if (fetch_if.mem_data_valid !== 1'b0 || bus_if.bus_req !== 1'b0) ok = 1'b0;
        end
        bus_if.bus_ack = 1'b0;
        chk("late_ack_ignored", 32'(ok), 32'd1);
        chk("late_ack_data",    fetch_if.mem_data, NOP);
        chk("late_ack_count",   req_count, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
